// File: rtl/scancode_filter.sv
// Scan-code decoder that tracks per-channel "active" flags from make/break codes.
// Optional auto-release hold timers are enabled by defining SCANCODE_HOLD_EN.
module scancode_filter #(
    parameter int unsigned          NUM_CH         = 2,
    parameter logic [NUM_CH*8-1:0]  CH_CODES       = {8'h33, 8'h2C},
    parameter logic [7:0]           ALL_CODE       = 8'h1C,
    parameter logic [7:0]           BREAK_CODE     = 8'hF0,
    parameter logic [7:0]           EXT_CODE       = 8'hE0,
    parameter int unsigned          TIMEOUT_CYCLES = 1000,
    parameter int unsigned          HOLD_CYCLES    = 50000
) (
    input  logic              CLK_clk_i,
    input  logic              RST_rst_i,
    input  logic [7:0]        dout_i,
    input  logic              dout_valid_i,
    output logic [NUM_CH-1:0] Sensor_o,
    output logic              code_hit_o,
    output logic              err_o
);

    // state      | meaning
    // ST_IDLE    | no prefix pending; non-prefix bytes are make codes
    // ST_BRK     | break prefix seen; next byte is a break code
    // ST_EXT     | extended prefix seen; next byte is discarded
    // ST_EXT_BRK | extended + break prefix seen; next byte is discarded
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [NUM_CH-1:0] sensor_q, sensor_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] match_mask;
    logic [NUM_CH-1:0] sel_mask;
    logic [NUM_CH-1:0] set_mask;
    logic [NUM_CH-1:0] clr_mask;
    logic [NUM_CH-1:0] rel_mask;
    logic              is_prefix;

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            match_mask[i] = (dout_i == CH_CODES[8*i +: 8]);
        end
    end

    // ALL_CODE overrides any channel that happens to share its value.
    assign sel_mask  = (dout_i == ALL_CODE) ? {NUM_CH{1'b1}} : match_mask;
    assign is_prefix = (dout_i == BREAK_CODE) || (dout_i == EXT_CODE);

    always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            sensor_q <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            sensor_q <= sensor_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        set_mask = '0;
        clr_mask = '0;
        hit_d    = 1'b0;
        err_d    = 1'b0;
        if (dout_valid_i) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (dout_i == BREAK_CODE) begin
                        state_d = ST_BRK;
                    end else if (dout_i == EXT_CODE) begin
                        state_d = ST_EXT;
                    end else begin
                        set_mask = sel_mask;
                        hit_d    = |sel_mask;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (is_prefix) begin
                        err_d = 1'b1;
                    end else begin
                        clr_mask = sel_mask;
                        hit_d    = |sel_mask;
                    end
                end
                ST_EXT: begin
                    if (dout_i == BREAK_CODE) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = (dout_i == EXT_CODE);
                    end
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    err_d   = is_prefix;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
        // A make in the same cycle as an auto-release keeps the flag set.
        sensor_d = (sensor_q & ~clr_mask & ~rel_mask) | set_mask;
    end

`ifdef SCANCODE_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_hold
        logic [HOLD_W-1:0] hold_q;

        always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
            if (!RST_rst_i) begin
                hold_q <= '0;
            end else if (set_mask[g]) begin
                hold_q <= HOLD_RELOAD;
            end else if (clr_mask[g]) begin
                hold_q <= '0;
            end else if (sensor_q[g] && (hold_q != '0)) begin
                hold_q <= hold_q - 1'b1;
            end
        end

        assign rel_mask[g] = sensor_q[g] && (hold_q == HOLD_W'(1));
    end
`else
    assign rel_mask = '0;
`endif

    assign Sensor_o   = sensor_q;
    assign code_hit_o = hit_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_scancode_filter.sv
// Directed self-checking bench for scancode_filter (channel 0 = 8'h33, channel 1 = 8'h2C).
// Hold-timer checks are selected by SCANCODE_HOLD_EN, matching the RTL build.
module tb_scancode_filter;

    logic       clk;
    logic       rst_n;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] sensor;
    logic       code_hit;
    logic       err;

    int n_chk = 0;
    int n_err = 0;

    scancode_filter #(
        .NUM_CH         (2),
        .CH_CODES       ({8'h2C, 8'h33}),
        .ALL_CODE       (8'h1C),
        .BREAK_CODE     (8'hF0),
        .EXT_CODE       (8'hE0),
        .TIMEOUT_CYCLES (16),
        .HOLD_CYCLES    (32)
    ) dut (
        .CLK_clk_i    (clk),
        .RST_rst_i    (rst_n),
        .dout_i       (dout),
        .dout_valid_i (dout_valid),
        .Sensor_o     (sensor),
        .code_hit_o   (code_hit),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; byte is taken on the next rising edge and
    // outputs are sampled at the falling edge that follows.
    task automatic send(input logic [7:0] b);
        dout       = b;
        dout_valid = 1'b1;
        @(negedge clk);
        dout_valid = 1'b0;
        dout       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        dout       = 8'h00;
        dout_valid = 1'b0;
        #3;
        chk("reset_sensor", 16'(sensor), 16'h0);
        chk("reset_hit",    16'(code_hit), 16'h0);
        chk("reset_err",    16'(err), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // make then break of channel 1
        send(8'h2C);
        chk("make_2c_sensor", 16'(sensor), 16'h2);
        chk("make_2c_hit",    16'(code_hit), 16'h1);
        idle(1);
        chk("hit_one_cycle",  16'(code_hit), 16'h0);
        send(8'hF0);
        chk("brk_prefix_hit", 16'(code_hit), 16'h0);
        chk("brk_prefix_sensor", 16'(sensor), 16'h2);
        send(8'h2C);
        chk("break_2c_sensor", 16'(sensor), 16'h0);
        chk("break_2c_hit",    16'(code_hit), 16'h1);

        // all-code make, single break, extended discard
        send(8'h1C);
        chk("make_all_sensor", 16'(sensor), 16'h3);
        send(8'hF0);
        send(8'h33);
        chk("break_33_sensor", 16'(sensor), 16'h2);
        chk("break_33_hit",    16'(code_hit), 16'h1);
        send(8'hE0);
        send(8'h2C);
        chk("ext_2c_sensor", 16'(sensor), 16'h2);
        chk("ext_2c_hit",    16'(code_hit), 16'h0);
        chk("ext_2c_err",    16'(err), 16'h0);

        // break-all, then prefix timeout
        send(8'hF0);
        send(8'h1C);
        chk("break_all_sensor", 16'(sensor), 16'h0);
        send(8'hF0);
        idle(15);
        chk("tmo_not_yet", 16'(err), 16'h0);
        idle(1);
        chk("tmo_err_pulse", 16'(err), 16'h1);
        chk("tmo_sensor",    16'(sensor), 16'h0);
        idle(1);
        chk("tmo_err_one_cycle", 16'(err), 16'h0);
        send(8'h33);
        chk("after_tmo_make", 16'(sensor), 16'h1);
        chk("after_tmo_hit",  16'(code_hit), 16'h1);

        // double prefix error
        send(8'hF0);
        send(8'hF0);
        chk("dbl_prefix_err",    16'(err), 16'h1);
        chk("dbl_prefix_sensor", 16'(sensor), 16'h1);
        send(8'h2C);
        chk("after_dbl_make", 16'(sensor), 16'h3);
        chk("after_dbl_err",  16'(err), 16'h0);

        // asynchronous reset during pending prefix
        send(8'hF0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sensor", 16'(sensor), 16'h0);
        chk("async_rst_hit",    16'(code_hit), 16'h0);
        chk("async_rst_err",    16'(err), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h2C);
        chk("post_rst_make", 16'(sensor), 16'h2);
        chk("post_rst_hit",  16'(code_hit), 16'h1);

        send(8'hF0);
        send(8'h1C);
        send(8'h33);
        chk("hold_start", 16'(sensor), 16'h1);
`ifdef SCANCODE_HOLD_EN
        idle(31);
        chk("hold_before_release", 16'(sensor), 16'h1);
        idle(1);
        chk("hold_released", 16'(sensor), 16'h0);
        chk("hold_release_hit", 16'(code_hit), 16'h0);
        send(8'h33);
        for (int k = 0; k < 5; k++) begin
            idle(19);
            chk("hold_refresh", 16'(sensor), 16'h1);
            send(8'h33);
        end
        idle(25);
        chk("hold_refresh_end", 16'(sensor), 16'h1);
`else
        idle(1000);
        chk("no_hold_sticky", 16'(sensor), 16'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scancode_filter.md
SCANCODE_FILTER -- requirements
Module: scancode_filter

Interface
REQ-001 Parameters: NUM_CH (default 2): number of sensor channels, 1..8.
REQ-002 CH_CODES (default {8'h33,8'h2C}): NUM_CH*8-bit flat vector of make codes; channel i uses bits [8i+7:8i].
REQ-003 ALL_CODE (default 8'h1C): make code that asserts every channel.
REQ-004 BREAK_CODE (default 8'hF0): break prefix. EXT_CODE (default 8'hE0): extended prefix.
REQ-005 TIMEOUT_CYCLES (default 1000): prefix-wait limit in clocks. HOLD_CYCLES (default 50000): auto-release time, used only under the configuration macro.
REQ-006 CLK_clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 RST_rst_i  in  1  asynchronous, active-low reset.
REQ-008 dout_i  in  8  received scan-code byte.
REQ-009 dout_valid_i  in  1  one-cycle strobe; dout_i is valid while it is high.
REQ-010 Sensor_o  out  NUM_CH  registered per-channel active flags.
REQ-011 code_hit_o  out  1  one-cycle pulse when a byte changes or refreshes any flag.
REQ-012 err_o  out  1  one-cycle pulse on prefix timeout or on a prefix arriving while a prefix is pending.

Function
REQ-013 FSM states: IDLE, BRK (break prefix seen), EXT (extended prefix seen), EXT_BRK (E0 then F0 seen).
REQ-014 Bytes are processed only in cycles where dout_valid_i=1; all other cycles leave the state unchanged, apart from the timeout and hold counters.
REQ-015 IDLE + BREAK_CODE -> BRK. IDLE + EXT_CODE -> EXT. IDLE + other byte -> make handling; state stays IDLE.
REQ-016 EXT + BREAK_CODE -> EXT_BRK. EXT + other byte -> IDLE; the byte is discarded, and extended codes never match a channel.
REQ-017 BRK + byte -> break handling, then IDLE. EXT_BRK + byte -> IDLE; the byte is discarded.
REQ-018 Make handling:
  - byte == ALL_CODE: set all Sensor_o bits.
  - else byte == channel i code: set Sensor_o[i].
  - no match: no change.
REQ-019 Break handling:
  - byte == ALL_CODE: clear all bits.
  - byte == channel i code: clear Sensor_o[i].
REQ-020 ALL_CODE takes priority over a channel code of equal value. If several channels share a code, all of them update.
REQ-021 code_hit_o pulses in the cycle after a matching make or break byte is accepted; Sensor_o updates in that same cycle (1-cycle latency).
REQ-022 In BRK, EXT or EXT_BRK, a 16-bit timeout counter counts clocks without a valid byte.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1: return to IDLE and pulse err_o; Sensor_o is unchanged.
REQ-024 A valid byte resets the timeout counter.
REQ-025 In BRK or EXT_BRK, a byte equal to BREAK_CODE or EXT_CODE pulses err_o and returns to IDLE; the byte is not used as a prefix.
REQ-026 Repeated make codes (typematic) set already-set bits and pulse code_hit_o.

Reset
REQ-027 Asserting RST_rst_i low immediately forces: state IDLE, Sensor_o=0, code_hit_o=0, err_o=0, all counters 0, with no clock required.
REQ-028 Reset during a pending prefix discards the prefix; the first byte after release is decoded from IDLE.
REQ-029 Release of RST_rst_i is synchronous to CLK_clk_i; the first edge after release is a normal operating edge.

Configuration
REQ-030 Macro SCANCODE_HOLD_EN, when defined, adds one hold counter per channel.
REQ-031 With SCANCODE_HOLD_EN, hold counter behaviour:
  - reloads to HOLD_CYCLES whenever its channel is set or refreshed by a make;
  - decrements while Sensor_o[i]=1;
  - at 1, clears Sensor_o[i] on the next edge without pulsing code_hit_o;
  - a break code clears the flag and zeroes the counter.
REQ-032 Without SCANCODE_HOLD_EN, no hold counters exist, and flags clear only by break code or reset.

Verification (NUM_CH=2, defaults, TIMEOUT_CYCLES=16, HOLD_CYCLES=32)
REQ-033 Valid 8'h2C -> Sensor_o=2'b10 and code_hit_o pulse one cycle later; then F0,2C -> Sensor_o=2'b00.
REQ-034 Valid 8'h1C -> Sensor_o=2'b11; then F0,33 -> 2'b10; then E0,2C -> 2'b10 unchanged, with no code_hit_o pulse.
REQ-035 Valid F0, then 16 idle clocks -> err_o pulse and state IDLE; next 8'h33 -> Sensor_o=2'b01 (make, not break).
REQ-036 Valid F0, then RST_rst_i low mid-clock -> outputs 0 before the next edge; after release, 8'h2C -> Sensor_o=2'b10.
REQ-037 With SCANCODE_HOLD_EN: 8'h33, then 32 idle clocks -> Sensor_o[0] clears. Repeating 8'h33 every 20 clocks -> Sensor_o[0] stays 1.
REQ-038 Without SCANCODE_HOLD_EN: 8'h33, then 1000 idle clocks -> Sensor_o=2'b01 still.
